// File: rtl/md_unit_pkg.sv
// Shared encodings and defaults for the MIPS multiply/divide unit:
// MDOp and HiLoWr codes, FSM states and default latencies.
package md_unit_pkg;

    localparam int MD_OP_W        = 3;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MSUB  = 3'b100
    } md_op_e;

    typedef enum logic [1:0] {
        HL_NONE = 2'b00,
        HL_MTHI = 2'b01,
        HL_MTLO = 2'b10,
        HL_RSVD = 2'b11
    } hilowr_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    function automatic logic md_op_valid(input logic [MD_OP_W-1:0] op);
        return (op <= 3'b100);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// Controller/register-file side of the multiply/divide unit: launch strobe,
// operands, mthi/mtlo write port, and the HI/LO/Busy results.
interface md_unit_if;
    import md_unit_pkg::*;

    logic               Start;
    logic [MD_OP_W-1:0] MDOp;
    logic [31:0]        A;
    logic [31:0]        B;
    logic [1:0]         HiLoWr;
    logic [31:0]        WD;
    logic               Busy;
    logic [31:0]        HI;
    logic [31:0]        LO;

    modport slave (
        input  Start, MDOp, A, B, HiLoWr, WD,
        output Busy, HI, LO
    );

    modport master (
        output Start, MDOp, A, B, HiLoWr, WD,
        input  Busy, HI, LO
    );

endinterface

// File: rtl/md_unit.sv
// Fixed-latency MIPS multiply/divide unit holding architectural HI/LO.
// Results are formed combinationally from latched operands and committed on the last RUN cycle.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave bus
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_state_e          r_state;
    md_state_e          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    md_op_e             r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_launch;
    logic               w_commit;
    logic               w_wr_hi;
    logic               w_wr_lo;
    logic               w_is_div;

    logic signed [63:0] w_sa;
    logic signed [63:0] w_sb;
    logic signed [63:0] w_sprod;
    logic [63:0]        w_uprod;
    logic [63:0]        w_msub;
    logic               w_div0;
    logic               w_sovf;
    logic signed [31:0] w_sdvs;
    logic signed [31:0] w_squo;
    logic signed [31:0] w_srem;
    logic [31:0]        w_udvs;
    logic [31:0]        w_uquo;
    logic [31:0]        w_urem;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    assign bus.Busy = (r_state == S_RUN);
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

    assign w_is_div = (bus.MDOp == MD_DIV) || (bus.MDOp == MD_DIVU);

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_commit    = 1'b0;
        w_wr_hi     = 1'b0;
        w_wr_lo     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Start) begin
                    if (md_op_valid(bus.MDOp)) begin
                        w_launch    = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end else begin
                    w_wr_hi = (bus.HiLoWr == HL_MTHI);
                    w_wr_lo = (bus.HiLoWr == HL_MTLO);
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_launch)
                r_cnt <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            else if (r_state == S_RUN)
                r_cnt <= r_cnt - 1'b1;
            if (w_commit) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_wr_hi) begin
                r_hi <= bus.WD;
            end else if (w_wr_lo) begin
                r_lo <= bus.WD;
            end
        end
    end

    // Operand latches carry no reset: they are only read after a launch loads them.
    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_op <= md_op_e'(bus.MDOp);
            r_a  <= bus.A;
            r_b  <= bus.B;
        end
    end

    assign w_sa    = {{32{r_a[31]}}, r_a};
    assign w_sb    = {{32{r_b[31]}}, r_b};
    assign w_sprod = w_sa * w_sb;
    assign w_uprod = {32'd0, r_a} * {32'd0, r_b};
    assign w_msub  = {r_hi, r_lo} - w_sprod;

    // A zero divisor or the -2^31 / -1 overflow both divide by 1 instead:
    // the overflow then yields the required quotient 0x80000000, remainder 0.
    assign w_div0 = (r_b == 32'd0);
    assign w_sovf = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
    assign w_sdvs = (w_div0 || w_sovf) ? 32'sd1 : $signed(r_b);
    assign w_squo = $signed(r_a) / w_sdvs;
    assign w_srem = $signed(r_a) % w_sdvs;
    assign w_udvs = w_div0 ? 32'd1 : r_b;
    assign w_uquo = r_a / w_udvs;
    assign w_urem = r_a % w_udvs;

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            MD_MULT:  {w_res_hi, w_res_lo} = w_sprod;
            MD_MULTU: {w_res_hi, w_res_lo} = w_uprod;
            MD_DIV: begin
                if (!w_div0) begin
                    w_res_hi = w_srem;
                    w_res_lo = w_squo;
                end
            end
            MD_DIVU: begin
                if (!w_div0) begin
                    w_res_hi = w_urem;
                    w_res_lo = w_uquo;
                end
            end
            MD_MSUB:  {w_res_hi, w_res_lo} = w_msub;
            default: begin
                w_res_hi = r_hi;
                w_res_lo = r_lo;
            end
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed-vector bench for md_unit: latency, HI/LO results, mthi/mtlo,
// reset abort, ignored strobes during RUN and back-to-back issue.
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   n;

    always #5 clk = ~clk;

    md_unit_if bus_if ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_if.Start = 1'b1;
        bus_if.MDOp  = op;
        bus_if.A     = a;
        bus_if.B     = b;
        tick();
        bus_if.Start = 1'b0;
        bus_if.MDOp  = 3'b000;
        bus_if.A     = 32'd0;
        bus_if.B     = 32'd0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (bus_if.Busy && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    task automatic mtx(input logic [1:0] sel, input logic [31:0] d);
        bus_if.HiLoWr = sel;
        bus_if.WD     = d;
        tick();
        bus_if.HiLoWr = 2'b00;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat,
                          input logic [31:0] hi, input logic [31:0] lo);
        int cnt;
        issue(op, a, b);
        check({tag, "_busy"}, 64'(bus_if.Busy), 64'd1);
        wait_idle(cnt);
        check({tag, "_lat"}, 64'(cnt), 64'(lat));
        check({tag, "_hilo"}, {bus_if.HI, bus_if.LO}, {hi, lo});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus_if.Start  = 1'b0;
        bus_if.MDOp   = 3'b000;
        bus_if.A      = 32'd0;
        bus_if.B      = 32'd0;
        bus_if.HiLoWr = 2'b00;
        bus_if.WD     = 32'd0;
        tick();
        tick();
        check("rst_busy", 64'(bus_if.Busy), 64'd0);
        check("rst_hilo", {bus_if.HI, bus_if.LO}, 64'd0);
        reset = 1'b0;
        tick();

        mtx(2'b01, 32'h1);
        mtx(2'b10, 32'h2);
        check("mt_hilo", {bus_if.HI, bus_if.LO}, {32'h1, 32'h2});

        // Abort a divide in its fourth busy cycle.
        issue(3'b010, 32'd100, 32'd7);
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(bus_if.Busy), 64'd0);
        check("abort_hilo", {bus_if.HI, bus_if.LO}, 64'd0);
        tick();
        reset = 1'b0;
        repeat (12) tick();
        check("abort_later_hilo", {bus_if.HI, bus_if.LO}, 64'd0);
        check("abort_later_busy", 64'(bus_if.Busy), 64'd0);

        run_op("mult",  3'b000, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'b001, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div",   3'b010, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", 3'b011, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        mtx(2'b01, 32'h1234_5678);
        mtx(2'b10, 32'h9);
        run_op("msub", 3'b100, 32'd3, 32'd3, 5, 32'h1234_5678, 32'h0000_0000);

        mtx(2'b01, 32'h0);
        mtx(2'b10, 32'h0);
        run_op("msub_neg", 3'b100, 32'hFFFF_FFFF, 32'd1, 5, 32'h0, 32'h1);

        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
        run_op("divu",    3'b011, 32'hFFFF_FFFF, 32'h10, 10, 32'hF, 32'h0FFF_FFFF);

        // Start and mthi in the same idle cycle: divide by zero keeps HI, so WD must never land.
        bus_if.HiLoWr = 2'b01;
        bus_if.WD     = 32'hDEAD_BEEF;
        issue(3'b011, 32'd5, 32'd0);
        bus_if.HiLoWr = 2'b00;
        check("startwr_hi_now", 64'(bus_if.HI), 64'h0000_000F);
        wait_idle(n);
        check("startwr_lat", 64'(n), 64'd10);
        check("startwr_hilo", {bus_if.HI, bus_if.LO}, {32'hF, 32'h0FFF_FFFF});

        // Strobes during RUN must be dropped.
        issue(3'b000, 32'd2, 32'd3);
        tick();
        bus_if.Start = 1'b1;
        bus_if.MDOp  = 3'b010;
        bus_if.A     = 32'd100;
        bus_if.B     = 32'd7;
        tick();
        bus_if.Start  = 1'b0;
        bus_if.HiLoWr = 2'b10;
        bus_if.WD     = 32'h55;
        tick();
        bus_if.HiLoWr = 2'b00;
        wait_idle(n);
        check("runign_lat", 64'(n), 64'd2);
        check("runign_hilo", {bus_if.HI, bus_if.LO}, {32'h0, 32'h6});
        tick();
        check("runign_busy_after", 64'(bus_if.Busy), 64'd0);

        // Back-to-back issue in the first non-busy cycle.
        issue(3'b000, 32'h0001_0000, 32'h0001_0000);
        wait_idle(n);
        check("b2b_mult_lat", 64'(n), 64'd5);
        check("b2b_mult_hilo", {bus_if.HI, bus_if.LO}, {32'h1, 32'h0});
        check("b2b_gap_busy", 64'(bus_if.Busy), 64'd0);
        run_op("b2b_div", 3'b010, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        issue(3'b111, 32'd1, 32'd1);
        check("badop_busy", 64'(bus_if.Busy), 64'd0);
        check("badop_hilo", {bus_if.HI, bus_if.LO}, {32'd2, 32'd14});

        mtx(2'b11, 32'hAAAA_AAAA);
        check("hl11_hilo", {bus_if.HI, bus_if.LO}, {32'd2, 32'd14});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
